// File: rtl/dds_voice_array.sv
// Time-multiplexed multi-voice DDS: one adder and one waveform generator serve all voices once per sample period.
// Optional SAT_MIX_EN: full-scale saturating mix instead of the default averaged mix.
module dds_voice_array #(
    parameter int NUM_VOICES = 4,
    parameter int ACC_W      = 16,
    parameter int OUT_W      = 12,
    parameter int SAMPLE_DIV = 8,
    parameter int VIDX_W     = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              wr_en,
    input  logic [VIDX_W-1:0] wr_voice,
    input  logic [ACC_W-1:0]  wr_tune,
    input  logic [1:0]        wr_wave,
    input  logic              wr_clr,
    output logic [OUT_W-1:0]  sample_out,
    output logic              sample_valid,
    output logic              busy
);

    localparam int SUM_W = OUT_W + VIDX_W;
    localparam int DIV_W = $clog2(SAMPLE_DIV);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_OUT  = 2'd2;

    localparam logic [1:0] WAVE_SIL = 2'd0;
    localparam logic [1:0] WAVE_SAW = 2'd1;
    localparam logic [1:0] WAVE_SQR = 2'd2;
    localparam logic [1:0] WAVE_TRI = 2'd3;

    localparam logic [VIDX_W-1:0] LAST_V  = VIDX_W'(NUM_VOICES - 1);
    localparam logic [DIV_W-1:0]  DIV_MAX = DIV_W'(SAMPLE_DIV - 1);

    logic [ACC_W-1:0]        acc_r  [NUM_VOICES];
    logic [ACC_W-1:0]        tune_r [NUM_VOICES];
    logic [1:0]              wave_r [NUM_VOICES];
    logic [DIV_W-1:0]        div_cnt_r;
    logic [1:0]              state_r;
    logic [VIDX_W-1:0]       vidx_r;
    logic signed [SUM_W-1:0] acc_sum_r;
    logic [OUT_W-1:0]        sample_out_r;
    logic                    sample_valid_r;
    logic                    busy_r;

    logic                    tick_s;
    logic                    wr_ok_s;
    logic [NUM_VOICES-1:0]   wr_hit_s;
    logic [NUM_VOICES-1:0]   run_hit_s;
    logic [OUT_W-1:0]        voice_s;
    logic signed [SUM_W-1:0] sum_next_s;
    logic [OUT_W-1:0]        mix_s;

    // Offset-binary phase bits become signed samples by flipping the MSB (subtracting half scale).
    function automatic logic [OUT_W-1:0] wave_gen(input logic [1:0] wave, input logic m,
                                                  input logic [OUT_W-1:0] p, input logic [OUT_W-1:0] t);
        logic [OUT_W-1:0] half;
        half = {1'b1, {(OUT_W-1){1'b0}}};
        case (wave)
            WAVE_SIL: wave_gen = {OUT_W{1'b0}};
            WAVE_SAW: wave_gen = p ^ half;
            WAVE_SQR: wave_gen = m ? half : ~half;
            WAVE_TRI: wave_gen = (m ? ~t : t) ^ half;
            default:  wave_gen = {OUT_W{1'b0}};
        endcase
    endfunction

    assign tick_s  = en && (div_cnt_r == DIV_MAX);
    assign wr_ok_s = wr_en && ({1'b0, wr_voice} < (VIDX_W+1)'(NUM_VOICES));

    // Per-voice write and processing selects.
    always_comb begin
        wr_hit_s  = {NUM_VOICES{1'b0}};
        run_hit_s = {NUM_VOICES{1'b0}};
        for (int v = 0; v < NUM_VOICES; v++) begin
            wr_hit_s[v]  = wr_ok_s && (wr_voice == VIDX_W'(v));
            run_hit_s[v] = (state_r == ST_RUN) && (vidx_r == VIDX_W'(v));
        end
    end

    // Shared waveform generator and adder for the voice selected this cycle.
    always_comb begin
        voice_s    = wave_gen(wave_r[vidx_r], acc_r[vidx_r][ACC_W-1],
                              acc_r[vidx_r][ACC_W-1 -: OUT_W], acc_r[vidx_r][ACC_W-2 -: OUT_W]);
        sum_next_s = acc_sum_r + {{VIDX_W{voice_s[OUT_W-1]}}, voice_s};
    end

`ifdef SAT_MIX_EN
    localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [SUM_W-1:0] SAT_MIN = -SUM_W'(2 ** (OUT_W - 1));

    // Full-scale mix, clipped to the output range.
    always_comb begin
        if (sum_next_s > SAT_MAX) begin
            mix_s = {1'b0, {(OUT_W-1){1'b1}}};
        end else if (sum_next_s < SAT_MIN) begin
            mix_s = {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            mix_s = sum_next_s[OUT_W-1:0];
        end
    end
`else
    // Averaged mix: taking the top OUT_W bits is an arithmetic shift by VIDX_W (floor).
    always_comb begin
        mix_s = sum_next_s[SUM_W-1 -: OUT_W];
    end
`endif

    // Sample-period divider; holds while en is low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt_r <= {DIV_W{1'b0}};
        end else if (en) begin
            if (div_cnt_r == DIV_MAX) begin
                div_cnt_r <= {DIV_W{1'b0}};
            end else begin
                div_cnt_r <= div_cnt_r + DIV_W'(1);
            end
        end else begin
            div_cnt_r <= div_cnt_r;
        end
    end

    // Voice register file; a clear beats the same-cycle phase advance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                acc_r[v]  <= {ACC_W{1'b0}};
                tune_r[v] <= {ACC_W{1'b0}};
                wave_r[v] <= WAVE_SIL;
            end
        end else begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (wr_hit_s[v]) begin
                    tune_r[v] <= wr_tune;
                    wave_r[v] <= wr_wave;
                end
                if (wr_hit_s[v] && wr_clr) begin
                    acc_r[v] <= {ACC_W{1'b0}};
                end else if (run_hit_s[v]) begin
                    acc_r[v] <= acc_r[v] + tune_r[v];
                end
            end
        end
    end

    // Sequencer: the last RUN cycle registers the mix so sample_valid is high during OUT.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r        <= ST_IDLE;
            vidx_r         <= {VIDX_W{1'b0}};
            acc_sum_r      <= {SUM_W{1'b0}};
            sample_out_r   <= {OUT_W{1'b0}};
            sample_valid_r <= 1'b0;
            busy_r         <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    sample_valid_r <= 1'b0;
                    if (tick_s) begin
                        state_r   <= ST_RUN;
                        vidx_r    <= {VIDX_W{1'b0}};
                        acc_sum_r <= {SUM_W{1'b0}};
                        busy_r    <= 1'b1;
                    end
                end
                ST_RUN: begin
                    acc_sum_r <= sum_next_s;
                    if (vidx_r == LAST_V) begin
                        state_r        <= ST_OUT;
                        sample_out_r   <= mix_s;
                        sample_valid_r <= 1'b1;
                        busy_r         <= 1'b0;
                    end else begin
                        vidx_r <= vidx_r + VIDX_W'(1);
                    end
                end
                ST_OUT: begin
                    state_r        <= ST_IDLE;
                    sample_valid_r <= 1'b0;
                end
                default: begin
                    state_r        <= ST_IDLE;
                    sample_valid_r <= 1'b0;
                    busy_r         <= 1'b0;
                end
            endcase
        end
    end

    assign sample_out   = sample_out_r;
    assign sample_valid = sample_valid_r;
    assign busy         = busy_r;

endmodule

// File: tb/tb_dds_voice_array.sv
// Directed bench for dds_voice_array: table of voice setups plus hand-written timing sequences.
module tb_dds_voice_array;

    localparam int NV = 4;
    localparam int AW = 16;
    localparam int OW = 12;
    localparam int SD = 8;
    localparam int VW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          wr_en;
    logic [VW-1:0] wr_voice;
    logic [AW-1:0] wr_tune;
    logic [1:0]    wr_wave;
    logic          wr_clr;
    logic [OW-1:0] sample_out;
    logic          sample_valid;
    logic          busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dds_voice_array #(.NUM_VOICES(NV), .ACC_W(AW), .OUT_W(OW), .SAMPLE_DIV(SD), .VIDX_W(VW)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .wr_en(wr_en), .wr_voice(wr_voice),
        .wr_tune(wr_tune), .wr_wave(wr_wave), .wr_clr(wr_clr),
        .sample_out(sample_out), .sample_valid(sample_valid), .busy(busy)
    );

    typedef struct packed {
        logic [3:0]         mask;
        logic [1:0]         wave;
        logic [15:0]        tune;
        logic signed [31:0] s0;
        logic signed [31:0] s1;
        logic signed [31:0] s2;
        logic signed [31:0] s3;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Expected output from the raw sum of the four voice samples.
    function automatic int mix(input int sum);
`ifdef SAT_MIX_EN
        if (sum > 2047) return 2047;
        else if (sum < -2048) return -2048;
        else return sum;
`else
        return sum >>> 2;
`endif
    endfunction

    task automatic wait_sample(output int val);
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            if (sample_valid === 1'b1) begin
                val = int'($signed(sample_out));
                return;
            end
        end
        total++;
        bad++;
        $display("FAIL sample_timeout: got no sample_valid expected one within 64 cycles");
        val = 99999;
    endtask

    task automatic wait_busy();
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            if (busy === 1'b1) return;
        end
        total++;
        bad++;
        $display("FAIL busy_timeout: got busy=0 expected busy=1 within 64 cycles");
    endtask

    task automatic write_voice(input int v, input logic [15:0] tune, input logic [1:0] wave, input logic clr);
        @(negedge clk);
        wr_en    = 1'b1;
        wr_voice = v[VW-1:0];
        wr_tune  = tune;
        wr_wave  = wave;
        wr_clr   = clr;
        @(negedge clk);
        wr_en  = 1'b0;
        wr_clr = 1'b0;
    endtask

    task automatic configure(input logic [3:0] mask, input logic [1:0] wave, input logic [15:0] tune, input logic clr);
        for (int v = 0; v < NV; v++) begin
            if (mask[v]) write_voice(v, tune, wave, clr);
            else write_voice(v, 16'h0000, 2'd0, clr);
        end
    endtask

    task automatic quiesce();
        @(negedge clk);
        en = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        int val;
        int exp_sum;
        int first_k;
        int vcount;
        int busy7;
        int busy8;
        int samples [17];

        vecs[0] = '{4'b0001, 2'd1, 16'h1000, -2048, -1792, -1536, -1280};
        vecs[1] = '{4'b1111, 2'd2, 16'h8000,  8188, -8192,  8188, -8192};
        vecs[2] = '{4'b0010, 2'd3, 16'h2000, -2048, -1024,     0,  1024};
        vecs[3] = '{4'b0100, 2'd2, 16'h4000,  2047,  2047, -2048, -2048};
        vecs[4] = '{4'b1111, 2'd0, 16'h1234,     0,     0,     0,     0};
        vecs[5] = '{4'b1000, 2'd1, 16'hF000, -2048,  1792,  1536,  1280};
        vecs[6] = '{4'b1111, 2'd1, 16'h0800, -8192, -7680, -7168, -6656};

        rst_n = 1'b0; en = 1'b0; wr_en = 1'b0; wr_voice = '0;
        wr_tune = '0; wr_wave = 2'd0; wr_clr = 1'b0;

        // Reset values, then first-sample latency after release.
        @(negedge clk);
        @(negedge clk);
        check("reset_sample_out", int'(sample_out), 0);
        check("reset_valid", int'(sample_valid), 0);
        check("reset_busy", int'(busy), 0);
        rst_n = 1'b1;
        en    = 1'b1;
        first_k = -1; vcount = 0; busy7 = -1; busy8 = -1; val = 99999;
        for (int k = 1; k < 20; k++) begin
            @(negedge clk);
            if (k == 7) busy7 = int'(busy);
            if (k == 8) busy8 = int'(busy);
            if (sample_valid === 1'b1) begin
                vcount++;
                if (first_k < 0) begin
                    first_k = k;
                    val = int'($signed(sample_out));
                end
            end
        end
        check("first_valid_cycle", first_k, 12);
        check("first_sample_value", val, 0);
        check("valid_one_cycle", vcount, 1);
        check("busy_before_run", busy7, 0);
        check("busy_in_run", busy8, 1);

        // Table of single-setup waveforms.
        for (int i = 0; i < 7; i++) begin
            quiesce();
            configure(vecs[i].mask, vecs[i].wave, vecs[i].tune, 1'b1);
            @(negedge clk);
            en = 1'b1;
            for (int j = 0; j < 4; j++) begin
                wait_sample(val);
                case (j)
                    0: exp_sum = vecs[i].s0;
                    1: exp_sum = vecs[i].s1;
                    2: exp_sum = vecs[i].s2;
                    default: exp_sum = vecs[i].s3;
                endcase
                check($sformatf("vec%0d_s%0d", i, j), val, mix(exp_sum));
            end
            if (i == 4) begin
                // Silent voices kept advancing: acc0 = 4*0x1234, p = 0x48D.
                quiesce();
                write_voice(0, 16'h0000, 2'd1, 1'b0);
                @(negedge clk);
                en = 1'b1;
                wait_sample(val);
                check("silent_phase_advance", val, mix(1165 - 2048));
            end
        end

        // Saw phase wraps after 16 samples.
        quiesce();
        configure(4'b0001, 2'd1, 16'h1000, 1'b1);
        @(negedge clk);
        en = 1'b1;
        for (int j = 0; j < 17; j++) wait_sample(samples[j]);
        check("saw_s15", samples[15], mix(1792));
        check("saw_wrap_s16", samples[16], mix(-2048));

        // Write to voice 2 while it is being processed.
        quiesce();
        configure(4'b0100, 2'd1, 16'h1000, 1'b1);
        @(negedge clk);
        en = 1'b1;
        wait_busy();
        @(negedge clk);
        @(negedge clk);
        wr_en = 1'b1; wr_voice = 2'd2; wr_tune = 16'h2000; wr_wave = 2'd1; wr_clr = 1'b0;
        @(negedge clk);
        wr_en = 1'b0;
        wait_sample(val);
        check("collide_cur", val, mix(-2048));
        wait_sample(val);
        check("collide_next", val, mix(-1792));
        wait_busy();
        @(negedge clk);
        @(negedge clk);
        wr_en = 1'b1; wr_voice = 2'd2; wr_tune = 16'h2000; wr_wave = 2'd1; wr_clr = 1'b1;
        @(negedge clk);
        wr_en = 1'b0; wr_clr = 1'b0;
        wait_sample(val);
        check("clr_collide_cur", val, mix(-1280));
        wait_sample(val);
        check("clr_collide_next", val, mix(-2048));

        // en dropped mid-RUN: sample completes, divider holds at 1.
        quiesce();
        configure(4'b0001, 2'd1, 16'h1000, 1'b1);
        @(negedge clk);
        en = 1'b1;
        wait_busy();
        @(negedge clk);
        en = 1'b0;
        wait_sample(val);
        check("en_low_completes", val, mix(-2048));
        vcount = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (sample_valid === 1'b1 || busy === 1'b1) vcount++;
        end
        check("en_low_no_tick", vcount, 0);
        en = 1'b1;
        first_k = -1; val = 99999;
        for (int k = 1; k < 20; k++) begin
            @(negedge clk);
            if (sample_valid === 1'b1 && first_k < 0) begin
                first_k = k;
                val = int'($signed(sample_out));
            end
        end
        check("en_resume_latency", first_k, 11);
        check("en_resume_value", val, mix(-1792));

        // Reset while voice 1 is being processed.
        quiesce();
        configure(4'b1111, 2'd2, 16'h3000, 1'b1);
        @(negedge clk);
        en = 1'b1;
        wait_sample(val);
        wait_sample(val);
        wait_busy();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("midrun_rst_out", int'(sample_out), 0);
        check("midrun_rst_busy", int'(busy), 0);
        rst_n = 1'b1;
        first_k = -1; val = 99999;
        for (int k = 1; k < 20; k++) begin
            @(negedge clk);
            if (sample_valid === 1'b1 && first_k < 0) begin
                first_k = k;
                val = int'($signed(sample_out));
            end
        end
        check("midrun_rst_no_valid", first_k, 12);
        check("midrun_rst_sample", val, 0);
        quiesce();
        configure(4'b1111, 2'd1, 16'h0000, 1'b0);
        @(negedge clk);
        en = 1'b1;
        wait_sample(val);
        check("midrun_rst_acc_zero", val, mix(-8192));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion expected finish before 2ms");
        $fatal(1, "watchdog expired");
    end

endmodule
